// File: rtl/hp_command_sequencer_if.sv
// ----------------------------------------------------------------------------
// hp_command_sequencer_if
// Request/response bundle between fabric logic and hp_command_sequencer.
//   master : the requester (drives req_*, resp_ready; observes the rest)
//   slave  : the sequencer  (drives req_ready, resp_*; observes the rest)
// Signals:
//   req_valid/req_ready      request handshake
//   req_write                1 write, 0 read
//   req_address[31:0]        byte address
//   req_data[23:0]           write data bits [31:8] of the AXI beat
//   req_id[5:0]              AXI id
//   resp_valid/resp_ready    response handshake
//   resp_write               response belongs to a write
//   resp_data[31:0]          read data, 0 for writes and timeouts
//   resp_response[1:0]       BRESP/RRESP
//   resp_id[5:0]             returned id
//   resp_timeout             transaction aborted by a poll timeout
// ----------------------------------------------------------------------------
interface hp_command_sequencer_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_address;
   logic [23:0] req_data;
   logic [5:0]  req_id;
   logic        resp_valid;
   logic        resp_ready;
   logic        resp_write;
   logic [31:0] resp_data;
   logic [1:0]  resp_response;
   logic [5:0]  resp_id;
   logic        resp_timeout;

   modport master (
      output req_valid, req_write, req_address, req_data, req_id, resp_ready,
      input  req_ready, resp_valid, resp_write, resp_data, resp_response,
             resp_id, resp_timeout
   );

   modport slave (
      input  req_valid, req_write, req_address, req_data, req_id, resp_ready,
      output req_ready, resp_valid, resp_write, resp_data, resp_response,
             resp_id, resp_timeout
   );
endinterface

// File: rtl/hp_command_sequencer.sv
// ----------------------------------------------------------------------------
// hp_command_sequencer
// Drives the HP stimulator's 32-bit GPIO command port ({cmd[7:0], field[23:0]})
// so that one request on the bus interface becomes a complete single-beat AXI3
// transaction: set fields, poll ready, SEND, poll valid, read back, CLEAR, and
// one response beat back to the requester.
// Ports:
//   clock     in   single clock, posedge
//   reset_n   in   asynchronous active-low reset
//   bus       slave modport of hp_command_sequencer_if (req_* / resp_*)
//   gpio_out  out  registered command word to the stimulator
//   gpio_in   in   stimulator reply, combinational on gpio_out
// Optional feature: define HP_SEQ_LAST_CHECK_EN to add a GET_LAST step after
// GET_DATA on reads; a missing rlast turns the response into SLVERR.
// ----------------------------------------------------------------------------
module hp_command_sequencer #(
   parameter logic [3:0] CACHE          = 4'b0011,
   parameter logic [2:0] PROTECTION     = 3'b000,
   parameter logic [1:0] BURST          = 2'b01,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic                  clock,
   input  logic                  reset_n,
   hp_command_sequencer_if.slave bus,
   output logic [31:0]           gpio_out,
   input  logic [31:0]           gpio_in
);
   localparam logic [7:0] CMD_DATA         = 8'd0;
   localparam logic [7:0] CMD_ADDR_LO      = 8'd1;
   localparam logic [7:0] CMD_ADDR_HI      = 8'd2;
   localparam logic [7:0] CMD_CACHE        = 8'd3;
   localparam logic [7:0] CMD_PROT         = 8'd4;
   localparam logic [7:0] CMD_ID           = 8'd5;
   localparam logic [7:0] CMD_WRITE        = 8'd6;
   localparam logic [7:0] CMD_BURST        = 8'd7;
   localparam logic [7:0] CMD_SEND         = 8'd8;
   localparam logic [7:0] CMD_GET_READY    = 8'd9;
   localparam logic [7:0] CMD_GET_DATA     = 8'd10;
   localparam logic [7:0] CMD_GET_WRITE    = 8'd11;
   localparam logic [7:0] CMD_GET_VALID    = 8'd12;
   localparam logic [7:0] CMD_GET_RESPONSE = 8'd13;
   localparam logic [7:0] CMD_GET_ID       = 8'd14;
   localparam logic [7:0] CMD_GET_LAST     = 8'd15;
   localparam logic [7:0] CMD_CLEAR        = 8'd16;

   localparam int               CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [4:0] {
      S_INIT, S_IDLE, S_CACHE, S_PROT, S_BURST, S_DATA, S_ADDR_LO, S_ADDR_HI,
      S_ID, S_WRITE, S_POLL_READY, S_SEND, S_POLL_VALID, S_GET_RESPONSE,
      S_GET_ID, S_GET_WRITE, S_GET_DATA, S_GET_LAST, S_CLEAR, S_RESP
   } state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] poll_cnt;
   logic             poll_expired;
   logic             timeout_hit;
   logic             accept;

   logic [31:0]      lat_address;
   logic [23:0]      lat_data;
   logic [5:0]       lat_id;
   logic             lat_write;

   logic             r_write;
   logic [31:0]      r_data;
   logic [1:0]       r_response;
   logic [5:0]       r_id;
   logic             r_timeout;

   // Command word presented while the sequencer sits in state s. IDLE, RESP
   // and POLL_VALID all use GET_VALID, which has no side effects.
   function automatic logic [31:0] word_for(input state_t s, input logic [31:0] addr,
                                            input logic [23:0] data, input logic [5:0] id,
                                            input logic wr);
      logic [31:0] w;
      case (s)
         S_INIT, S_CLEAR: w = {CMD_CLEAR, 24'h0};
         S_CACHE:         w = {CMD_CACHE, 20'h0, CACHE};
         S_PROT:          w = {CMD_PROT, 21'h0, PROTECTION};
         S_BURST:         w = {CMD_BURST, 22'h0, BURST};
         S_DATA:          w = {CMD_DATA, data};
         S_ADDR_LO:       w = {CMD_ADDR_LO, addr[23:0]};
         S_ADDR_HI:       w = {CMD_ADDR_HI, 16'h0, addr[31:24]};
         S_ID:            w = {CMD_ID, 18'h0, id};
         S_WRITE:         w = {CMD_WRITE, 23'h0, wr};
         S_POLL_READY:    w = {CMD_GET_READY, 24'h0};
         S_SEND:          w = {CMD_SEND, 24'h0};
         S_GET_RESPONSE:  w = {CMD_GET_RESPONSE, 24'h0};
         S_GET_ID:        w = {CMD_GET_ID, 24'h0};
         S_GET_WRITE:     w = {CMD_GET_WRITE, 24'h0};
         S_GET_DATA:      w = {CMD_GET_DATA, 24'h0};
         S_GET_LAST:      w = {CMD_GET_LAST, 24'h0};
         default:         w = {CMD_GET_VALID, 24'h0};
      endcase
      return w;
   endfunction

   assign accept       = (state == S_IDLE) && bus.req_valid;
   assign poll_expired = (poll_cnt == CNT_MAX);

   assign bus.req_ready     = (state == S_IDLE);
   assign bus.resp_valid    = (state == S_RESP);
   assign bus.resp_write    = r_write;
   assign bus.resp_data     = r_data;
   assign bus.resp_response = r_response;
   assign bus.resp_id       = r_id;
   assign bus.resp_timeout  = r_timeout;

   always_comb begin
      state_next  = state;
      timeout_hit = 1'b0;
      case (state)
         S_INIT:       state_next = S_IDLE;
         S_IDLE:       if (bus.req_valid) state_next = S_CACHE;
         S_CACHE:      state_next = S_PROT;
         S_PROT:       state_next = S_BURST;
         S_BURST:      state_next = lat_write ? S_DATA : S_ADDR_LO;
         S_DATA:       state_next = S_ADDR_LO;
         S_ADDR_LO:    state_next = S_ADDR_HI;
         S_ADDR_HI:    state_next = S_ID;
         S_ID:         state_next = S_WRITE;
         S_WRITE:      state_next = S_POLL_READY;
         // A reply arriving in the last permitted cycle still wins over expiry.
         S_POLL_READY: begin
            if (gpio_in[2:0] == 3'b111) begin
               state_next = S_SEND;
            end else if (poll_expired) begin
               state_next  = S_CLEAR;
               timeout_hit = 1'b1;
            end
         end
         S_SEND:       state_next = S_POLL_VALID;
         S_POLL_VALID: begin
            if (gpio_in[0]) begin
               state_next = S_GET_RESPONSE;
            end else if (poll_expired) begin
               state_next  = S_CLEAR;
               timeout_hit = 1'b1;
            end
         end
         S_GET_RESPONSE: state_next = S_GET_ID;
         S_GET_ID:       state_next = S_GET_WRITE;
         S_GET_WRITE:    state_next = lat_write ? S_CLEAR : S_GET_DATA;
`ifdef HP_SEQ_LAST_CHECK_EN
         S_GET_DATA:     state_next = S_GET_LAST;
         S_GET_LAST:     state_next = S_CLEAR;
`else
         S_GET_DATA:     state_next = S_CLEAR;
`endif
         S_CLEAR:        state_next = S_RESP;
         S_RESP:         if (bus.resp_ready) state_next = S_IDLE;
         default:        state_next = S_INIT;
      endcase
   end

   // State and gpio_out move together so the word always matches the state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_INIT;
         gpio_out   <= {CMD_CLEAR, 24'h0};
         poll_cnt   <= '0;
         r_write    <= 1'b0;
         r_data     <= '0;
         r_response <= '0;
         r_id       <= '0;
         r_timeout  <= 1'b0;
      end else begin
         state    <= state_next;
         gpio_out <= word_for(state_next, lat_address, lat_data, lat_id, lat_write);

         // Restarts on every state change, so each poll state begins at zero.
         if (state_next != state) begin
            poll_cnt <= '0;
         end else if (poll_cnt != CNT_MAX) begin
            poll_cnt <= poll_cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (accept) begin
                  r_write    <= bus.req_write;
                  r_data     <= '0;
                  r_response <= '0;
                  r_id       <= '0;
                  r_timeout  <= 1'b0;
               end
            end
            S_POLL_READY, S_POLL_VALID: if (timeout_hit) r_timeout <= 1'b1;
            S_GET_RESPONSE: r_response <= gpio_in[1:0];
            S_GET_ID:       r_id       <= gpio_in[5:0];
            S_GET_WRITE:    r_write    <= gpio_in[0];
            S_GET_DATA:     r_data     <= gpio_in;
`ifdef HP_SEQ_LAST_CHECK_EN
            S_GET_LAST:     if (!gpio_in[0]) r_response <= 2'b10;
`endif
            default: ;
         endcase
      end
   end

   // Request fields are only meaningful after an accept, so they carry no reset.
   always_ff @(posedge clock) begin
      if (accept) begin
         lat_address <= bus.req_address;
         lat_data    <= bus.req_data;
         lat_id      <= bus.req_id;
         lat_write   <= bus.req_write;
      end
   end
endmodule
